// File: rtl/shift_sequencer_if.sv
// Request/response bus between datapath control and the shift sequencer.
interface shift_sequencer_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 3
);
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  din;
  logic          busy;
  logic          done;
  logic [N-1:0]  dout;

  modport master (
    output start, op, amt, din,
    input  busy, done, dout
  );

  modport slave (
    input  start, op, amt, din,
    output busy, done, dout
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step controller driving an external single-step shifter one step per clock.
// Shifts by N or more collapse to a single clear step; rotates iterate the full amount.
module shift_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave io_bus,
  output logic [N-1:0]     o_sh_f,
  output logic [2:0]       o_sh_h,
  input  logic [N-1:0]     i_sh_s
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  localparam logic [2:0] CodePass = 3'b000;
  localparam logic [2:0] CodeShl  = 3'b001;
  localparam logic [2:0] CodeShr  = 3'b010;
  localparam logic [2:0] CodeClr  = 3'b011;
  localparam logic [2:0] CodeRol  = 3'b101;
  localparam logic [2:0] CodeRor  = 3'b110;

  state_e        r_state, w_state_d;
  logic [N-1:0]  r_wreg, w_wreg_d;
  logic [AW-1:0] r_cnt, w_cnt_d;
  logic [2:0]    r_code, w_code_d;
  logic [N-1:0]  r_dout, w_dout_d;
  logic          r_done;
  logic          r_busy;
  logic [2:0]    w_op_code;
  logic          w_amt_ge_n;

  always_comb begin
    unique case (io_bus.op)
      2'b00: w_op_code = CodeShl;
      2'b01: w_op_code = CodeShr;
      2'b10: w_op_code = CodeRol;
      2'b11: w_op_code = CodeRor;
    endcase
  end

  assign w_amt_ge_n = 32'(io_bus.amt) >= N;

  always_comb begin
    w_state_d = r_state;
    w_wreg_d  = r_wreg;
    w_cnt_d   = r_cnt;
    w_code_d  = r_code;
    o_sh_h    = CodePass;
    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_wreg_d = io_bus.din;
          if (io_bus.amt == '0) begin
            w_code_d  = w_op_code;
            w_cnt_d   = '0;
            w_state_d = StDone;
          end else if (!io_bus.op[1] && w_amt_ge_n) begin
            // Everything is shifted out anyway: one clear step does the job.
            w_code_d  = CodeClr;
            w_cnt_d   = AW'(1);
            w_state_d = StShift;
          end else begin
            w_code_d  = w_op_code;
            w_cnt_d   = io_bus.amt;
            w_state_d = StShift;
          end
        end
      end
      StShift: begin
        o_sh_h   = r_code;
        w_wreg_d = i_sh_s;
        w_cnt_d  = r_cnt - AW'(1);
        if (r_cnt == AW'(1)) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    // Result is captured on entry to DONE so it is visible alongside the done pulse.
    w_dout_d = (w_state_d == StDone) ? w_wreg_d : r_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_wreg  <= '0;
      r_cnt   <= '0;
      r_code  <= CodePass;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_wreg  <= w_wreg_d;
      r_cnt   <= w_cnt_d;
      r_code  <= w_code_d;
      r_dout  <= w_dout_d;
      r_done  <= (w_state_d == StDone);
      r_busy  <= (w_state_d != StIdle);
    end
  end

  assign o_sh_f      = r_wreg;
  assign io_bus.busy = r_busy;
  assign io_bus.done = r_done;
  assign io_bus.dout = r_dout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: models the external shifter, checks step timing per vector
// and compares every done result against a scoreboard queue.
module tb_shift_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 3;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] sh_f;
  logic [2:0]   sh_h;
  logic [N-1:0] sh_s;

  shift_sequencer_if #(.N(N), .AW(AW)) bus ();

  shift_sequencer #(.N(N), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus),
    .o_sh_f (sh_f),
    .o_sh_h (sh_h),
    .i_sh_s (sh_s)
  );

  // Reference single-step shifter attached to the sh_* ports.
  always_comb begin
    case (sh_h)
      3'b001:  sh_s = {sh_f[N-2:0], 1'b0};
      3'b010:  sh_s = {1'b0, sh_f[N-1:1]};
      3'b011:  sh_s = '0;
      3'b101:  sh_s = {sh_f[N-2:0], sh_f[N-1]};
      3'b110:  sh_s = {sh_f[0], sh_f[N-1:1]};
      default: sh_s = sh_f;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  din;
    logic [N-1:0]  exp;
    int            k;
    logic [2:0]    code;
  } vec_t;

  vec_t         vecs[11];
  logic [N-1:0] sb_q[$];
  int           checks;
  int           failures;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(bus.dout), 32'hdead);
      end else begin
        check("dout_sb", 32'(bus.dout), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic run_op(input vec_t v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = v.op;
    bus.amt   = v.amt;
    bus.din   = v.din;
    sb_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= v.k + 2; c++) begin
      if (c <= v.k) begin
        check("shift_cycle", 32'({bus.busy, bus.done, sh_h}), 32'({1'b1, 1'b0, v.code}));
      end else if (c == v.k + 1) begin
        check("done_cycle", 32'({bus.busy, bus.done, sh_h}), 32'({1'b1, 1'b1, 3'b000}));
      end else begin
        check("idle_after", 32'({bus.busy, bus.done, bus.dout}), 32'({1'b0, 1'b0, v.exp}));
      end
      @(negedge clk);
    end
    check("dout_held", 32'(bus.dout), 32'(v.exp));
  endtask

  initial begin
    int ndone;
    int done_at;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.amt   = '0;
    bus.din   = '0;

    //              op     amt   din      exp      k  code
    vecs[0]  = '{2'b00, 3'd1, 4'b1011, 4'b0110, 1, 3'b001};
    vecs[1]  = '{2'b10, 3'd2, 4'b1011, 4'b1110, 2, 3'b101};
    vecs[2]  = '{2'b11, 3'd1, 4'b1011, 4'b1101, 1, 3'b110};
    vecs[3]  = '{2'b01, 3'd5, 4'b1111, 4'b0000, 1, 3'b011};
    vecs[4]  = '{2'b00, 3'd0, 4'b1011, 4'b1011, 0, 3'b000};
    vecs[5]  = '{2'b01, 3'd3, 4'b1001, 4'b0001, 3, 3'b010};
    vecs[6]  = '{2'b10, 3'd7, 4'b0110, 4'b0011, 7, 3'b101};
    vecs[7]  = '{2'b00, 3'd4, 4'b1101, 4'b0000, 1, 3'b011};
    vecs[8]  = '{2'b00, 3'd3, 4'b1101, 4'b1000, 3, 3'b001};
    vecs[9]  = '{2'b11, 3'd4, 4'b0011, 4'b0011, 4, 3'b110};
    vecs[10] = '{2'b01, 3'd3, 4'b1000, 4'b0001, 3, 3'b010};

    #12;
    check("reset_outputs", 32'({bus.busy, bus.done, bus.dout, sh_h, sh_f}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset", 32'({bus.busy, bus.done, bus.dout, sh_h, sh_f}), 32'h0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i]);
    end

    // Start pulses during an operation are dropped, not queued.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.amt   = 3'd3;
    bus.din   = 4'b0001;
    sb_q.push_back(4'b1000);
    @(posedge clk);
    ndone   = 0;
    done_at = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        done_at = c;
      end
      if (c == 1) begin
        bus.din = 4'b1111;
        bus.op  = 2'b01;
        bus.amt = 3'd1;
      end else if (c == 2) begin
        bus.din = 4'b0110;
      end else if (c == 3) begin
        bus.start = 1'b0;
      end
    end
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_at", 32'(done_at), 32'd4);

    // Reset mid-operation aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.amt   = 3'd3;
    bus.din   = 4'b1011;
    sb_q.push_back(4'b1000);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({bus.busy, bus.done, bus.dout, sh_h, sh_f}), 32'h0);
    sb_q.delete();
    @(negedge clk);
    check("abort_no_done", 32'({bus.busy, bus.done}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'({bus.busy, bus.done, bus.dout}), 32'h0);
    run_op(vecs[1]);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-step controller for the single-step N-bit shifter unit. It accepts an operand, a shift/rotate operation and a shift amount, then drives the shifter's `F`/`H` inputs for one step per clock, registering the shifter's `S` output back each cycle. It reports completion with a one-cycle `done` pulse and a held result. It sits between the datapath control logic and the combinational shifter, which is instantiated outside this block and wired via the `sh_*` ports.

## Interface
- `N`, 4, operand width in bits; must match the attached shifter, N ≥ 2.
- `AW`, 3, width of the shift-amount input; amounts 0 to 2^AW−1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 shift left, 01 shift right, 10 rotate left, 11 rotate right.
- `amt`  in  AW  shift/rotate amount; sampled with `start`.
- `din`  in  N  operand; sampled with `start`.
- `busy`  out  1  high while an operation is in progress (SHIFT and DONE states).
- `done`  out  1  one-cycle completion pulse.
- `dout`  out  N  result; updated in DONE and held until the next completion.
- `sh_f`  out  N  to shifter `F`; always equals the internal working register.
- `sh_h`  out  3  to shifter `H`; the step code.
- `sh_s`  in  N  from shifter `S`; the combinational one-step result.

## Operation
- States: IDLE, SHIFT, DONE.
- Step codes driven on `sh_h`:
  - 001: shift left, zero fill.
  - 010: shift right, zero fill.
  - 011: clear.
  - 101: rotate left.
  - 110: rotate right.
  - 000: pass, used in every non-SHIFT state.
- IDLE with `start`=1:
  - Load `wreg` ← `din` and latch the step code.
  - Load the step counter `cnt`:
    - `amt` = 0: `cnt` = 0, next state DONE.
    - Shift op (00/01) with `amt` ≥ N: use step code 011 with `cnt` = 1, so one clear step replaces N+ shifts.
    - Otherwise: `cnt` = `amt`, next state SHIFT.
  - Rotate ops iterate the full `amt` steps; no modulo reduction is applied.
- SHIFT, each cycle:
  - `sh_h` = latched code.
  - `wreg` ← `sh_s`, `cnt` ← `cnt` − 1.
  - When `cnt` = 1, next state is DONE.
- DONE, one cycle:
  - `done`=1, `dout` ← `wreg`, `busy`=1.
  - Next state IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; it is not queued.
- In IDLE, `start`=0: no state change; `dout` holds its value.
- `sh_s` is used only in SHIFT; its value in other states is don't-care.

## Timing
- Reset (async assert, whatever the state):
  - state IDLE, `wreg`=0, `cnt`=0.
  - `dout`=0, `busy`=0, `done`=0, `sh_h`=000, `sh_f`=0.
- Reset asserted mid-operation aborts the operation: no `done`, `dout` cleared to 0.
- `start` sampled at edge T:
  - `busy` is high from T+1.
  - With k = effective step count (`amt`, 1 for the clamped clear, 0 for `amt`=0), SHIFT occupies cycles T+1 through T+k.
  - `done` and the new `dout` are visible in cycle T+1+k; `busy` falls at T+2+k.
- Earliest next accepted `start` is at edge T+2+k, so throughput is one operation per k+2 cycles.
- The shifter path (`sh_f` → `sh_s` → `wreg`) is combinational within one cycle; this block adds no pipeline stage.
- `dout` and `done` are registered; no combinational path from inputs to outputs except `sh_f`/`sh_h` from state.

## Test plan
- Reset with `rst_n`=0, then release → all outputs 0, `sh_h`=000, `busy`=0.
- `din`=1011, `op`=00, `amt`=1, start at T → `sh_h`=001 in T+1, `done` at T+2, `dout`=0110.
- `din`=1011, `op`=10, `amt`=2 → two cycles of `sh_h`=101, `done` at T+3, `dout`=1110. Repeat with `op`=11, `amt`=1 → `dout`=1101 at T+2.
- `din`=1111, `op`=01, `amt`=5 (≥N) → single step with `sh_h`=011, `done` at T+2, `dout`=0000. Also `amt`=0 → `done` at T+1, `dout`=`din`, `sh_h` stays 000.
- Start with `amt`=3, pulse `start` again at T+1 and T+2 with different `din` → ignored, one `done` at T+4 with the first result only.
- Start with `amt`=3, assert `rst_n`=0 at T+2 → `busy`/`dout` go 0 immediately, no `done`; the next start after release behaves normally.
